// File: rtl/fsm_sched_pkg.sv
// Shared types and widths for the round-robin scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_sched_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } sched_state_e;

endpackage

// File: rtl/fsm_sched_if.sv
// Requester/scheduler/shared-unit signal bundle.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until granted; done is sampled only in WAIT.
interface fsm_sched_if
    import fsm_sched_pkg::*;
#(
    parameter int N = 4
) ();
    localparam int W = $clog2(N);

    logic [N-1:0]       req;
    logic [N-1:0]       grant;
    logic [N-1:0]       ack;
    logic [W-1:0]       owner;
    logic               start;
    logic               done;
    logic               busy;
    logic               timeout_err;
    logic [STATE_W-1:0] sched_state;

    // Scheduler side
    modport master (
        input  req, done,
        output grant, ack, owner, start, busy, timeout_err, sched_state
    );

    // Requesters / shared unit side
    modport slave (
        output req, done,
        input  grant, ack, owner, start, busy, timeout_err, sched_state
    );
endinterface

// File: rtl/fsm_sched_rr_pick.sv
// Round-robin winner search starting one past the last owner.
// Latency: combinational.
// Backpressure: none; win_vld low when no request is pending.
module rr_pick #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_owner,
    output logic [W-1:0] win_idx,
    output logic         win_vld
);

    logic [W-1:0] cand;

    // Walk indices last_owner+1 .. last_owner+N (mod N); first set request wins
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = W'((int'(last_owner) + i) % N);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

endmodule

// File: rtl/fsm_sched.sv
// Round-robin scheduler granting one requester at a time access to a shared unit.
// Latency: grant registered 1 cycle after req; at least 4 cycles grant-to-grant.
// Backpressure: owner holds grant until done or wait timeout; other requesters wait.
module fsm_sched
    import fsm_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    fsm_sched_if.master    bus
);

    localparam int W = $clog2(N);

    sched_state_e state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [W-1:0] owner_q, owner_d;
    logic [W-1:0] last_owner_q, last_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         busy_q, busy_d;

    logic [W-1:0] win_idx;
    logic         win_vld;
    logic         start_dat;
    logic [N-1:0] ack_dat;

    rr_pick #(.N(N)) u_rr_pick (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .win_idx    (win_idx),
        .win_vld    (win_vld)
    );

    // State register; last_owner resets to N-1 so requester 0 wins first
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= W'(N - 1);
            cnt_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; done outside WAIT is deliberately not looked at
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (win_vld) begin
                    state_d          = START;
                    grant_d[win_idx] = 1'b1;
                    owner_d          = win_idx;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.done) begin
                    state_d = ACK;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d      = IDLE;
                grant_d      = '0;
                last_owner_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Pulse outputs decoded straight from the registered state
    always_comb begin
        start_dat = (state_q == START);
        ack_dat   = '0;
        if (state_q == ACK) begin
            ack_dat[owner_q] = 1'b1;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner       = owner_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = err_q;
    assign bus.sched_state = state_q;
    assign bus.start       = start_dat;
    assign bus.ack         = ack_dat;

endmodule

// File: tb/tb_fsm_sched.sv
module tb_fsm_sched;
    import fsm_sched_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fsm_sched_if #(.N(4)) bus ();

    fsm_sched #(.N(4), .TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] ack;
        logic       err;
    } ack_exp_t;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] exp_grant_q[$];
    ack_exp_t   exp_ack_q[$];
    logic [3:0] prev_grant  = 4'b0;
    logic [3:0] e_grant;
    ack_exp_t   e_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int n;
        n = 0;
        while (bus.sched_state !== s && n < budget) begin
            tick();
            n++;
        end
        if (bus.sched_state !== s) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_state: got %0d expected %0d within %0d cycles", bus.sched_state, s, budget);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic has_ack, input logic err);
        ack_exp_t a;
        exp_grant_q.push_back(g);
        if (has_ack) begin
            a.ack = g;
            a.err = err;
            exp_ack_q.push_back(a);
        end
    endtask

    // Monitor: compares each new grant and each ack pulse against the scoreboard
    always @(negedge clock) begin
        if (reset) begin
            if (bus.grant != 4'b0 && prev_grant == 4'b0) begin
                if (exp_grant_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL grant_unexpected: got %b expected none", bus.grant);
                end else begin
                    e_grant = exp_grant_q.pop_front();
                    chk("grant", 32'(bus.grant), 32'(e_grant));
                end
            end
            if (bus.ack != 4'b0) begin
                if (exp_ack_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ack_unexpected: got %b expected none", bus.ack);
                end else begin
                    e_ack = exp_ack_q.pop_front();
                    chk("ack", 32'(bus.ack), 32'(e_ack.ack));
                    chk("ack_timeout_err", 32'(bus.timeout_err), 32'(e_ack.err));
                end
            end
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
        end
        prev_grant = bus.grant;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.req  = 4'b0;
        bus.done = 1'b0;
        reset    = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_state", 32'(bus.sched_state), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.timeout_err), 32'd0);
        reset = 1'b1;
        tick();

        // Single requester, done three cycles after start
        push(4'b0001, 1'b1, 1'b0);
        bus.req = 4'b0001;
        tick();
        chk("t1_state_start", 32'(bus.sched_state), 32'd1);
        chk("t1_start", 32'(bus.start), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_owner", 32'(bus.owner), 32'd0);
        bus.req = 4'b0;
        tick();
        chk("t1_state_wait", 32'(bus.sched_state), 32'd2);
        chk("t1_start_once", 32'(bus.start), 32'd0);
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t1_state_ack", 32'(bus.sched_state), 32'd3);
        tick();
        chk("t1_busy_after", 32'(bus.busy), 32'd0);
        chk("t1_grant_after", 32'(bus.grant), 32'd0);

        // Contention: all four requesting after reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        push(4'b0001, 1'b1, 1'b0);
        push(4'b0010, 1'b1, 1'b0);
        push(4'b0100, 1'b1, 1'b0);
        push(4'b1000, 1'b1, 1'b0);
        push(4'b0001, 1'b1, 1'b0);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_state(2'd2, 10);
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
        end
        bus.req = 4'b0;
        tick();
        tick();
        chk("t2_idle", 32'(bus.sched_state), 32'd0);
        chk("t2_grant_idle", 32'(bus.grant), 32'd0);

        // Spurious done while idle
        bus.done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_state", 32'(bus.sched_state), 32'd0);
            chk("t3_ack", 32'(bus.ack), 32'd0);
            chk("t3_err", 32'(bus.timeout_err), 32'd0);
        end
        bus.done = 1'b0;

        // One-cycle request still completes
        push(4'b0100, 1'b1, 1'b0);
        bus.req = 4'b0100;
        tick();
        bus.req = 4'b0;
        chk("t4_state_start", 32'(bus.sched_state), 32'd1);
        wait_state(2'd2, 5);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t4_state_ack", 32'(bus.sched_state), 32'd3);
        tick();
        chk("t4_idle", 32'(bus.sched_state), 32'd0);

        // Timeout after exactly 8 WAIT cycles
        push(4'b0010, 1'b1, 1'b1);
        bus.req = 4'b0010;
        tick();
        chk("t5_owner", 32'(bus.owner), 32'd1);
        bus.req = 4'b0;
        tick();
        for (int k = 1; k < 8; k++) begin
            chk("t5_waiting", 32'(bus.sched_state), 32'd2);
            tick();
        end
        chk("t5_last_wait", 32'(bus.sched_state), 32'd2);
        chk("t5_err_not_yet", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("t5_state_ack", 32'(bus.sched_state), 32'd3);
        chk("t5_err_set", 32'(bus.timeout_err), 32'd1);
        tick();
        chk("t5_grant_after", 32'(bus.grant), 32'd0);
        tick();
        tick();
        chk("t5_err_sticky", 32'(bus.timeout_err), 32'd1);

        // Reset mid-WAIT abandons silently; next request granted at once
        push(4'b0001, 1'b0, 1'b0);
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0;
        tick();
        tick();
        chk("t6_in_wait", 32'(bus.sched_state), 32'd2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t6_state", 32'(bus.sched_state), 32'd0);
        chk("t6_grant", 32'(bus.grant), 32'd0);
        chk("t6_ack", 32'(bus.ack), 32'd0);
        chk("t6_err_cleared", 32'(bus.timeout_err), 32'd0);
        push(4'b1000, 1'b1, 1'b0);
        bus.req = 4'b1000;
        tick();
        bus.req = 4'b0;
        chk("t6_regrant_state", 32'(bus.sched_state), 32'd1);
        chk("t6_regrant_owner", 32'(bus.owner), 32'd3);
        wait_state(2'd2, 5);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        tick();

        chk("grant_queue_drained", 32'(exp_grant_q.size()), 32'd0);
        chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
